playfield_scan_ctrl: RTL and testbench
======================================

// Module: playfield_scan_ctrl
// PURPOSE
//  Scan-out controller and RAM arbiter for the Tetris playfield. Consumes HCNT/VCNT/BLANK from the VGA timing generator.
//  Owns the single-port board RAM (one 30-bit word per board row) and shares it between display fetch and game logic.
//  Fetches one board row per video line into a line buffer during horizontal blank, then emits a per-pixel colour index.
// PARAMETERS
//  H_DISPW   640  active pixels per line
//  V_DISPW   480  active lines per frame
//  PF_X0     240  first playfield pixel column (>=1)
//  PF_Y0      80  first playfield line (>=1)
//  CELL       16  pixels per cell edge
//  COLS       10  board columns
//  ROWS       20  board rows
//  CW          3  colour-index width; 0 = empty cell
// PORTS
//  PCLK_I       in   1      pixel clock
//  RSTN_I       in   1      async reset, active low
//  HCNT_I       in   13     horizontal count from timing generator
//  VCNT_I       in   13     vertical count from timing generator
//  BLANK_I      in   1      1 = active video (data enable)
//  G_REQ_I      in   1      game access request; held high until G_ACK_O
//  G_WE_I       in   1      1 = write, 0 = read; stable while G_REQ_I is high
//  G_ADDR_I     in   5      board row
//  G_WDATA_I    in   COLS*CW  row data; cell c occupies bits [c*CW +: CW]
//  G_ACK_O      out  1      one-cycle completion pulse
//  G_RDATA_O    out  COLS*CW  read data; valid with G_ACK_O, held until the next read ack
//  RAM_EN_O     out  1      RAM enable
//  RAM_WE_O     out  1      RAM write enable
//  RAM_ADDR_O   out  5      RAM row address
//  RAM_WDATA_O  out  COLS*CW  RAM write data
//  RAM_RDATA_I  in   COLS*CW  RAM read data, valid 1 cycle after RAM_EN_O
//  PF_ACT_O     out  1      pixel lies inside the playfield
//  PF_COLOR_O   out  CW     cell colour index; 0 when PF_ACT_O = 0
//  FRAME_O      out  1      one-cycle pulse at start of vertical blank
// BEHAVIOUR
//  Reset: async and active low. All outputs go to 0, the FSM goes to IDLE, the line buffer is cleared to 0 and the row counters are cleared. Reset may abort an access in flight; that access is never acked and the requester re-presents it.
//  Fetch trigger:
//   - Fires when HCNT_I == H_DISPW and next line VCNT_I+1 lies in [PF_Y0, PF_Y0+ROWS*CELL).
//   - Fetch row is 0 when VCNT_I+1 == PF_Y0. The row advances by 1 each time the line-in-cell counter wraps CELL-1 -> 0. No dividers are used.
//  FSM states:
//   IDLE -> F_ADDR  when a trigger is present or pending. Fetch has strict priority over game access.
//   IDLE -> G_ADDR  when G_REQ_I is high and no fetch is pending.
//   F_ADDR: drive RAM_EN=1, WE=0, ADDR=fetch row -> F_DATA.
//   F_DATA: load RAM_RDATA_I into the line buffer -> IDLE.
//   G_ADDR: drive RAM_EN=1, WE=G_WE_I, ADDR=G_ADDR_I, WDATA=G_WDATA_I -> G_DATA.
//   G_DATA: capture RAM_RDATA_I (reads only) -> G_ACK. G_ACK: G_ACK_O=1 for one cycle -> IDLE.
//  Game access latency is 3 cycles from acceptance to ack.
//  A trigger arriving during a game access is latched as pending and serviced at the next IDLE. The worst-case deferral is 3 cycles, well inside horizontal blank.
//  G_ADDR_I >= ROWS: no RAM access (RAM_EN stays 0). G_ACK_O still pulses, and for a read G_RDATA_O = 0.
//  Same-cycle trigger and G_REQ_I in IDLE: fetch wins; the game request is granted after F_DATA.
//  A game write to the row currently on screen becomes visible from the next fetched line; no tearing within a line.
//  Pixel path (registered, latency 1 cycle from HCNT_I/VCNT_I):
//   - PF_ACT_O = BLANK_I && HCNT_I in [PF_X0, PF_X0+COLS*CELL) && VCNT_I in [PF_Y0, PF_Y0+ROWS*CELL).
//   - The column counter and pixel-in-cell counter load 0 at HCNT_I == PF_X0. The column advances when the pixel-in-cell counter wraps CELL-1 -> 0.
//   - PF_COLOR_O = linebuf[col] when active, else 0.
//  FRAME_O: pulses for one cycle when HCNT_I == 0 && VCNT_I == V_DISPW.
//  Widths: all counter compares are done at 13 bits; row and column counters saturate at ROWS-1 and COLS-1.
// STRUCTURE
//  Shared package vga_pkg: timing constants (H_DISPW, V_DISPW, totals).
//  Shared package tetris_pkg: COLS, ROWS, CW, colour codes, FSM state encodings.
//  Sub-module pf_line_buffer: COLS x CW register array with synchronous load of a full row, indexed combinational read and async clear.
//  Arbiter FSM and pixel counters stay in this module.
// TESTING
//  1. Reset low mid-frame -> all outputs 0, FSM in IDLE. Release at HCNT=0, VCNT=0 -> first RAM_EN at HCNT=H_DISPW, VCNT=PF_Y0-1 (640,79), address 0.
//  2. RAM row 0 = cells {1,2,...,7,0,1,2}. Line 80 -> PF_ACT_O high for HCNT 240..399 (output delayed 1 cycle); colour 1 over px 240..255 and 2 over px 256..271.
//  3. Line 95 -> 96 -> fetch address becomes 1. Line 399 fetched row 19. At VCNT=399 no further fetch is issued.
//  4. G_REQ_I write at HCNT=H_DISPW (same cycle as the trigger) -> fetch completes first, then RAM_WE_O=1 is issued, then G_ACK_O pulses.
//  5. G_REQ_I read of row 5 with RAM row 5 = 30'h2AAAAAAA -> G_ACK_O 3 cycles after grant and G_RDATA_O=30'h2AAAAAAA. A read of row 25 -> ack with data 0 and no RAM_EN.
//  6. At VCNT=480, HCNT=0 -> FRAME_O pulses exactly once per frame (once per 525 lines).

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, colour codes and scan-controller FSM encoding.
package tetris_pkg;
  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int CW     = 3;
  localparam int CELL   = 16;
  localparam int PF_X0  = 240;
  localparam int PF_Y0  = 80;
  localparam int RW     = COLS * CW;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = 5;
  localparam int CELL_W = $clog2(CELL);
  typedef logic [CW-1:0] color_t;
  localparam color_t C_EMPTY = 3'd0;
  localparam color_t C_I     = 3'd1;
  localparam color_t C_O     = 3'd2;
  localparam color_t C_T     = 3'd3;
  localparam color_t C_S     = 3'd4;
  localparam color_t C_Z     = 3'd5;
  localparam color_t C_J     = 3'd6;
  localparam color_t C_L     = 3'd7;
  typedef enum logic [2:0] {
    ST_IDLE, ST_F_ADDR, ST_F_DATA, ST_G_ADDR, ST_G_DATA, ST_G_ACK
  } state_t;
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 VGA timing constants shared by the video blocks.
package vga_pkg;
  localparam int CNT_W   = 13;
  localparam int H_DISPW = 640;
  localparam int V_DISPW = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
endpackage

// File: rtl/pf_line_buffer.sv
// pf_line_buffer: one board row of cell colours, loaded whole, read per column.
module pf_line_buffer
  import tetris_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [RW-1:0]    din,
  input  logic [COL_W-1:0] idx,
  output color_t           dout
);
  logic [RW-1:0] row_q, row_d;
  always_comb begin
    row_d = load ? din : row_q;
    dout  = (idx < COL_W'(COLS)) ? row_q[idx*CW +: CW] : C_EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) row_q <= '0;
    else        row_q <= row_d;
endmodule

// File: rtl/playfield_scan_ctrl.sv
// playfield_scan_ctrl: board RAM arbiter (line fetch vs game access) and
// per-pixel playfield colour generator.
module playfield_scan_ctrl
  import vga_pkg::*;
  import tetris_pkg::*;
(
  input  logic             PCLK_I,
  input  logic             RSTN_I,
  input  logic [CNT_W-1:0] HCNT_I,
  input  logic [CNT_W-1:0] VCNT_I,
  input  logic             BLANK_I,
  input  logic             G_REQ_I,
  input  logic             G_WE_I,
  input  logic [ROW_W-1:0] G_ADDR_I,
  input  logic [RW-1:0]    G_WDATA_I,
  output logic             G_ACK_O,
  output logic [RW-1:0]    G_RDATA_O,
  output logic             RAM_EN_O,
  output logic             RAM_WE_O,
  output logic [ROW_W-1:0] RAM_ADDR_O,
  output logic [RW-1:0]    RAM_WDATA_O,
  input  logic [RW-1:0]    RAM_RDATA_I,
  output logic             PF_ACT_O,
  output color_t           PF_COLOR_O,
  output logic             FRAME_O
);
  localparam logic [CNT_W-1:0] HD = CNT_W'(H_DISPW);
  localparam logic [CNT_W-1:0] VD = CNT_W'(V_DISPW);
  localparam logic [CNT_W-1:0] X0 = CNT_W'(PF_X0);
  localparam logic [CNT_W-1:0] X1 = CNT_W'(PF_X0 + COLS * CELL);
  localparam logic [CNT_W-1:0] Y0 = CNT_W'(PF_Y0);
  localparam logic [CNT_W-1:0] Y1 = CNT_W'(PF_Y0 + ROWS * CELL);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS - 1);
  localparam logic [CELL_W-1:0] CELL_MAX = CELL_W'(CELL - 1);

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [ROW_W-1:0]    frow_q, frow_d;
  logic [CELL_W-1:0]   flic_q, flic_d;
  logic [COL_W-1:0]    col_q, col_d, col_c;
  logic [CELL_W-1:0]   pic_q, pic_d, pic_c;
  logic                act_q, act_d;
  color_t              color_q, color_d, lb_color;
  logic                frame_q, frame_d;
  logic [RW-1:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]    vnext;
  logic                trig, g_ok, lb_load, at_x0;

  assign vnext = VCNT_I + 13'd1;
  assign trig  = (HCNT_I == HD) && (vnext >= Y0) && (vnext < Y1);
  assign g_ok  = G_ADDR_I < ROW_W'(ROWS);

  // Fetch row follows the trigger count, not VCNT, so no divide is needed.
  always_comb begin
    frow_d = frow_q;
    flic_d = flic_q;
    if (trig) begin
      flic_d = (vnext == Y0 || flic_q == CELL_MAX) ? '0 : flic_q + 1'b1;
      frow_d = (vnext == Y0) ? '0 :
               (flic_q == CELL_MAX && frow_q != ROW_MAX) ? frow_q + 1'b1 : frow_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q | trig;
    rdata_d     = rdata_q;
    lb_load     = 1'b0;
    G_ACK_O     = 1'b0;
    RAM_EN_O    = 1'b0;
    RAM_WE_O    = 1'b0;
    RAM_ADDR_O  = '0;
    RAM_WDATA_O = '0;
    case (state_q)
      ST_IDLE: begin
        if (pend_d) begin
          state_d = ST_F_ADDR;
          pend_d  = 1'b0;
        end else if (G_REQ_I) begin
          state_d = ST_G_ADDR;
        end
      end
      ST_F_ADDR: begin
        RAM_EN_O   = 1'b1;
        RAM_ADDR_O = frow_q;
        state_d    = ST_F_DATA;
      end
      ST_F_DATA: begin
        lb_load = 1'b1;
        state_d = ST_IDLE;
      end
      ST_G_ADDR: begin
        RAM_EN_O    = g_ok;
        RAM_WE_O    = g_ok && G_WE_I;
        RAM_ADDR_O  = G_ADDR_I;
        RAM_WDATA_O = G_WDATA_I;
        state_d     = ST_G_DATA;
      end
      ST_G_DATA: begin
        rdata_d = G_WE_I ? rdata_q : (g_ok ? RAM_RDATA_I : '0);
        state_d = ST_G_ACK;
      end
      ST_G_ACK: begin
        G_ACK_O = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters describe the pixel currently on HCNT_I; the output is its registered colour.
  always_comb begin
    at_x0   = HCNT_I == X0;
    col_c   = at_x0 ? '0 : col_q;
    pic_c   = at_x0 ? '0 : pic_q;
    pic_d   = (pic_c == CELL_MAX) ? '0 : pic_c + 1'b1;
    col_d   = (pic_c == CELL_MAX && col_c != COL_MAX) ? col_c + 1'b1 : col_c;
    act_d   = BLANK_I && HCNT_I >= X0 && HCNT_I < X1 && VCNT_I >= Y0 && VCNT_I < Y1;
    color_d = act_d ? lb_color : C_EMPTY;
    frame_d = (HCNT_I == 13'd0) && (VCNT_I == VD);
  end

  pf_line_buffer u_lb (
    .clk   (PCLK_I),
    .rst_n (RSTN_I),
    .load  (lb_load),
    .din   (RAM_RDATA_I),
    .idx   (col_c),
    .dout  (lb_color)
  );

  always_ff @(posedge PCLK_I or negedge RSTN_I)
    if (!RSTN_I) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      frow_q  <= '0;
      flic_q  <= '0;
      col_q   <= '0;
      pic_q   <= '0;
      act_q   <= 1'b0;
      color_q <= C_EMPTY;
      frame_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      frow_q  <= frow_d;
      flic_q  <= flic_d;
      col_q   <= col_d;
      pic_q   <= pic_d;
      act_q   <= act_d;
      color_q <= color_d;
      frame_q <= frame_d;
      rdata_q <= rdata_d;
    end

  assign PF_ACT_O   = act_q;
  assign PF_COLOR_O = color_q;
  assign FRAME_O    = frame_q;
  assign G_RDATA_O  = rdata_q;
endmodule

// File: tb/tb_playfield_scan_ctrl.sv
// tb_playfield_scan_ctrl: directed checks of fetch, arbitration, pixel path and frame pulse.
module tb_playfield_scan_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [12:0] hcnt = 13'd300, vcnt = 13'd200;
  logic        blank = 1'b1;
  logic        g_req = 1'b0, g_we = 1'b0;
  logic [4:0]  g_addr = '0;
  logic [29:0] g_wdata = '0;
  logic        g_ack;
  logic [29:0] g_rdata;
  logic        ram_en, ram_we;
  logic [4:0]  ram_addr;
  logic [29:0] ram_wdata;
  logic [29:0] ram_rdata = '0;
  logic        pf_act;
  logic [2:0]  pf_color;
  logic        frame;
  logic [29:0] ram [32];
  logic [29:0] w0;
  int n_chk = 0, n_err = 0;
  int row0_cells [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};

  playfield_scan_ctrl dut (
    .PCLK_I(clk), .RSTN_I(rstn), .HCNT_I(hcnt), .VCNT_I(vcnt), .BLANK_I(blank),
    .G_REQ_I(g_req), .G_WE_I(g_we), .G_ADDR_I(g_addr), .G_WDATA_I(g_wdata),
    .G_ACK_O(g_ack), .G_RDATA_O(g_rdata),
    .RAM_EN_O(ram_en), .RAM_WE_O(ram_we), .RAM_ADDR_O(ram_addr),
    .RAM_WDATA_O(ram_wdata), .RAM_RDATA_I(ram_rdata),
    .PF_ACT_O(pf_act), .PF_COLOR_O(pf_color), .FRAME_O(frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int h, input int v);
    hcnt = 13'(h);
    vcnt = 13'(v);
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
    for (int c = 0; c < 10; c++) ram[0][c*3 +: 3] = 3'(row0_cells[c]);
    for (int c = 0; c < 10; c++) w0[c*3 +: 3] = 3'd4;
    ram[5]  = 30'h2AAAAAAA;
    ram[19] = 30'h3FFFFFFF;

    // reset held mid-frame inside the playfield
    tick();
    tick();
    chk("rst_act", 32'(pf_act), 32'd0);
    chk("rst_color", 32'(pf_color), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ack", 32'(g_ack), 32'd0);
    chk("rst_rdata", 32'(g_rdata), 32'd0);
    hcnt = 13'd0; vcnt = 13'd0; blank = 1'b0;
    rstn = 1'b1;
    tick();

    // first fetch: row 0 for line 80
    px(639, 79);
    chk("pre_fetch_en", 32'(ram_en), 32'd0);
    px(640, 79);
    chk("fetch0", {ram_en, ram_we, ram_addr}, {25'd0, 1'b1, 1'b0, 5'd0});
    px(641, 79);
    px(642, 79);
    chk("fetch0_done", 32'(ram_en), 32'd0);

    // line 80 pixel path
    blank = 1'b1;
    for (int h = 236; h <= 402; h++) begin
      px(h, 80);
      chk("pix_act", 32'(pf_act), (h >= 240 && h < 400) ? 32'd1 : 32'd0);
      chk("pix_color", 32'(pf_color), (h >= 240 && h < 400) ? 32'(row0_cells[(h - 240) / 16]) : 32'd0);
    end
    blank = 1'b0;
    px(250, 80);
    chk("pix_noblank", {pf_act, pf_color}, 32'd0);

    // row advance across the board
    for (int v = 80; v <= 398; v++) begin
      px(640, v);
      chk("fetch_row", {ram_en, ram_addr}, {26'd1, 5'((v + 1 - 80) / 16)});
      px(641, v);
      px(642, v);
    end
    px(640, 399);
    chk("no_fetch_399", 32'(ram_en), 32'd0);
    px(641, 399);
    chk("no_fetch_399b", 32'(ram_en), 32'd0);

    // same-cycle trigger and game write: fetch wins
    g_req = 1'b1; g_we = 1'b1; g_addr = 5'd0; g_wdata = w0;
    px(640, 79);
    chk("tie_fetch", {ram_en, ram_we, ram_addr}, {25'd0, 1'b1, 1'b0, 5'd0});
    px(641, 79);
    chk("tie_fdata", {ram_en, g_ack}, 32'd0);
    px(642, 79);
    chk("tie_idle", {ram_en, g_ack}, 32'd0);
    px(643, 79);
    chk("tie_write", {ram_en, ram_we, ram_addr}, {25'd0, 1'b1, 1'b1, 5'd0});
    chk("tie_wdata", 32'(ram_wdata), 32'(w0));
    px(644, 79);
    chk("tie_gdata_ack", 32'(g_ack), 32'd0);
    px(645, 79);
    chk("tie_ack", 32'(g_ack), 32'd1);
    g_req = 1'b0; g_we = 1'b0;
    px(646, 79);
    chk("tie_ack_drop", 32'(g_ack), 32'd0);

    // old row stays on screen until refetched
    blank = 1'b1;
    px(240, 80);
    chk("old_row_color", 32'(pf_color), 32'd1);
    blank = 1'b0;
    px(640, 80);
    chk("refetch_row0", {ram_en, ram_addr}, {26'd1, 5'd0});
    px(641, 80);
    px(642, 80);
    blank = 1'b1;
    px(240, 81);
    chk("new_row_color", 32'(pf_color), 32'd4);
    blank = 1'b0;

    // read of row 5 with a trigger arriving mid-access
    g_req = 1'b1; g_addr = 5'd5;
    px(638, 81);
    chk("rd5_addr", {ram_en, ram_we, ram_addr}, {25'd0, 1'b1, 1'b0, 5'd5});
    px(639, 81);
    chk("rd5_wait", 32'(g_ack), 32'd0);
    px(640, 81);
    chk("rd5_ack", 32'(g_ack), 32'd1);
    chk("rd5_data", 32'(g_rdata), 32'h2AAAAAAA);
    g_req = 1'b0;
    px(641, 81);
    chk("pend_idle", {ram_en, g_ack}, 32'd0);
    px(642, 81);
    chk("pend_fetch", {ram_en, ram_addr}, {26'd1, 5'd0});
    px(643, 81);
    px(644, 81);
    chk("rd5_hold", 32'(g_rdata), 32'h2AAAAAAA);

    // out-of-range read
    g_req = 1'b1; g_addr = 5'd25;
    px(10, 200);
    chk("rd25_no_en", 32'(ram_en), 32'd0);
    px(11, 200);
    px(12, 200);
    chk("rd25_ack", {g_ack, g_rdata}, {1'b1, 30'd0});
    g_req = 1'b0;
    px(13, 200);

    // readback of the written row
    g_req = 1'b1; g_addr = 5'd0;
    px(20, 200);
    px(21, 200);
    px(22, 200);
    chk("rd0_ack", {g_ack, g_rdata}, {1'b1, w0});
    g_req = 1'b0;
    px(23, 200);

    // frame pulse
    px(0, 479);
    chk("frame_479", 32'(frame), 32'd0);
    px(0, 480);
    chk("frame_480", 32'(frame), 32'd1);
    px(1, 480);
    chk("frame_drop", 32'(frame), 32'd0);
    px(0, 481);
    chk("frame_481", 32'(frame), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
